pipe_addsub: RTL and testbench

- Parametrised, pipelined successor to the team's 4-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands with carry/borrow-in.
- Splits the carry chain into CHUNK-bit ripple slices, with a register stage between slices.
- Sits between operand producers and the datapath result bus. Uses a valid/ready handshake and sustains one operation per cycle when not stalled.

---
 rtl/pipe_addsub.sv | 130 +++++++++++++
 tb/tb_pipe_addsub.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: the carry chain is cut into CHUNK-bit ripple slices with a
// register stage between slices, behind a valid/ready handshake that stalls globally.
module pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_width
        $error("pipe_addsub: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    logic              advance;
    logic [STAGES-1:0] valid_d, valid_q;
    logic [STAGES-1:0] carry_d, carry_q;
    logic [WIDTH-1:0]  a_skew_d [STAGES];
    logic [WIDTH-1:0]  a_skew_q [STAGES];
    logic [WIDTH-1:0]  b_skew_d [STAGES];
    logic [WIDTH-1:0]  b_skew_q [STAGES];
    logic [WIDTH-1:0]  psum_d   [STAGES];
    logic [WIDTH-1:0]  psum_q   [STAGES];
    logic              msb_carry;

    logic [WIDTH-1:0]  sum_d, sum_q;
    logic              cout_d, cout_q;
    logic              ovf_d, ovf_q;
    logic              zero_d, zero_q;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign advance  = !valid_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    always_comb begin
        logic [WIDTH-1:0] a_in, b_in, s_in;
        logic             c_in, v_in;
        logic [CHUNK:0]   slice;
        // NOTE: every variable gets a default before any branch so no latch can be inferred.
        a_in      = '0;
        b_in      = '0;
        s_in      = '0;
        c_in      = 1'b0;
        v_in      = 1'b0;
        slice     = '0;
        msb_carry = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                // Subtraction is a + ~b + !cin, so the borrow-in becomes an inverted carry-in.
                a_in = a;
                b_in = op ? ~b : b;
                c_in = op ? ~cin : cin;
                s_in = '0;
                v_in = in_valid;
            end else begin
                a_in = a_skew_q[k-1];
                b_in = b_skew_q[k-1];
                c_in = carry_q[k-1];
                s_in = psum_q[k-1];
                v_in = valid_q[k-1];
            end
            slice = {1'b0, a_in[k*CHUNK +: CHUNK]} + {1'b0, b_in[k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, c_in};
            a_skew_d[k] = a_in;
            b_skew_d[k] = b_in;
            psum_d[k]   = s_in;
            psum_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
            carry_d[k]  = slice[CHUNK];
            valid_d[k]  = v_in;
            if (k == STAGES - 1) begin
                // Carry into the MSB recovered from the MSB sum bit and its operand bits.
                msb_carry = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ slice[CHUNK-1];
            end
        end
        sum_d  = psum_d[STAGES-1];
        cout_d = carry_d[STAGES-1];
        ovf_d  = carry_d[STAGES-1] ^ msb_carry;
        zero_d = (psum_d[STAGES-1] == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (advance) begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // NOTE: datapath stage registers carry no reset; their valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_skew_q[k] <= a_skew_d[k];
                b_skew_q[k] <= b_skew_d[k];
                psum_q[k]   <= psum_d[k];
            end
            carry_q <= carry_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=16, CHUNK=4): directed table, streaming,
// backpressure and mid-flight reset.
module tb_pipe_addsub;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int STAGES = WIDTH / CHUNK;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int   checks = 0;
    int   errors = 0;
    int   rx_cnt = 0;
    bit   mon_en = 1'b0;
    vec_t stream_v[$];
    vec_t tbl[12];

    pipe_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_out(input logic [15:0] s, input logic c, input logic v,
                                             input logic z);
        return {13'd0, s, c, v, z};
    endfunction

    // Reference: plain 17-bit arithmetic, overflow from operand/result sign rule.
    function automatic vec_t model(input logic [15:0] av, input logic [15:0] bv,
                                   input logic cv, input logic ov);
        vec_t        v;
        logic [15:0] be;
        logic [16:0] r;
        be     = ov ? ~bv : bv;
        r      = {1'b0, av} + {1'b0, be} + {16'd0, (ov ? ~cv : cv)};
        v.a    = av;
        v.b    = bv;
        v.cin  = cv;
        v.op   = ov;
        v.sum  = r[15:0];
        v.cout = r[16];
        v.ovf  = (av[15] == be[15]) && (r[15] != av[15]);
        v.zero = (r[15:0] == 16'd0);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        op       = v.op;
    endtask

    // Output monitor: compares every transferred result against the expected stream in order.
    always @(negedge clk) begin
        #2;
        if (mon_en && out_valid && out_ready) begin
            if (rx_cnt < stream_v.size())
                check("stream_result", pack_out(sum, cout, ovf, zero),
                      pack_out(stream_v[rx_cnt].sum, stream_v[rx_cnt].cout,
                               stream_v[rx_cnt].ovf, stream_v[rx_cnt].zero));
            else
                check("extra_result", 32'd1, 32'd0);
            rx_cnt++;
        end
    end

    task automatic run_stream(input bit do_stall);
        int tx;
        int iter;
        int stall_left;
        bit stall_done;
        int n;
        n          = stream_v.size();
        tx         = 0;
        iter       = 0;
        stall_left = 0;
        stall_done = 1'b0;
        rx_cnt     = 0;
        repeat (STAGES + 2) @(negedge clk);
        mon_en = 1'b1;
        while ((rx_cnt < n) && (iter < n + 200)) begin
            @(negedge clk);
            if (do_stall && !stall_done && out_valid && (rx_cnt == 3)) begin
                stall_left = 5;
                stall_done = 1'b1;
            end
            out_ready = (stall_left == 0);
            if (tx < n) drive(stream_v[tx]);
            else in_valid = 1'b0;
            #2;
            if (stall_left > 0) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_sum_hold", 32'(sum), 32'(stream_v[3].sum));
                stall_left--;
            end else if (!do_stall) begin
                check("stream_in_ready", 32'(in_ready), 32'd1);
                if ((iter >= STAGES) && (iter < n + STAGES))
                    check("stream_out_valid", 32'(out_valid), 32'd1);
            end
            if (in_valid && in_ready) tx++;
            iter++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mon_en    = 1'b0;
        check("stream_tx_count", 32'(tx), 32'(n));
        check("stream_rx_count", 32'(rx_cnt), 32'(n));
        if (do_stall) check("stall_seen", 32'(stall_done), 32'd1);
    endtask

    initial begin
        vec_t nv;

        tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op        = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {31'd0, out_valid} | pack_out(sum, cout, ovf, zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed table: each vector alone, exact latency checked on both sides.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (STAGES - 2) @(negedge clk);
            check($sformatf("vec%0d_early", i), 32'(out_valid), 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_result", i), pack_out(sum, cout, ovf, zero),
                  pack_out(tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].zero));
        end

        // 100 back-to-back random beats.
        stream_v.delete();
        for (int i = 0; i < 100; i++)
            stream_v.push_back(model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)));
        run_stream(1'b0);

        // 8 beats with a 5-cycle output stall while beat 3 is presented.
        stream_v.delete();
        for (int i = 0; i < 8; i++)
            stream_v.push_back(model(16'(16'h1111 * (i + 1)), 16'(16'h0F03 + i), 1'(i), 1'(i >> 1)));
        run_stream(1'b1);

        // Reset while three beats are in flight.
        repeat (STAGES + 2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_outputs", {31'd0, out_valid} | pack_out(sum, cout, ovf, zero), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        nv = model(16'hABCD, 16'h1357, 1'b1, 1'b0);
        drive(nv);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            check($sformatf("midrst_quiet%0d", i), 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        check("midrst_new_valid", 32'(out_valid), 32'd1);
        check("midrst_new_result", pack_out(sum, cout, ovf, zero),
              pack_out(nv.sum, nv.cout, nv.ovf, nv.zero));
        @(negedge clk);
        check("midrst_drained", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
